peak_tracker: RTL and testbench
===============================

Name: peak_tracker

Overview:
- Downstream consumer of the correlator-magnitude stream and its per-sample peak flag. The flag comes from the existing threshold peak detector, delayed upstream so that it is sample-aligned.
- Refines each coarse detection to the exact argmax sample index and reports it.
- After the first report, predicts the next peak one PERIOD later, gates detections to a tolerance window, and declares lock loss after consecutive misses.
- Feeds timing and frame-sync logic.

Parameters:
- IN_DW, 32, magnitude width.
- CNT_DW, 32, sample-index counter width.
- PERIOD, 19200, nominal peak spacing in valid samples.
- SEARCH_LEN, 8, refine window length in valid samples, including the detected sample.
- TOLERANCE, 4, half-width of the tracking window in samples.
- MAX_MISSES, 3, consecutive empty windows before lock loss.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- s_axis_in_tdata  in  IN_DW  unsigned correlator magnitude.
- s_axis_in_tvalid  in  1  sample valid.
- peak_detected_i  in  1  peak flag, qualifies the sample on s_axis_in_tdata in the same cycle.
- m_axis_out_tdata  out  CNT_DW  sample index of the reported peak.
- m_axis_out_tuser  out  IN_DW  magnitude of the reported peak.
- m_axis_out_tvalid  out  1  single-cycle report strobe; no backpressure.
- locked_o  out  1  tracking active.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset:
  - Asynchronous and active-low; one clock; all state in the clk_i domain.
  - Reset clears all outputs, the sample counter, the miss counter and the argmax registers, and puts the FSM in SEARCH.
  - Reset asserted mid-operation aborts immediately. No partial report is emitted.
- Sample counter:
  - sample_cnt increments on every accepted beat (s_axis_in_tvalid=1) and wraps modulo 2^CNT_DW.
  - A beat's index is the value of sample_cnt before the increment. The first beat after reset has index 0.
  - All index arithmetic is modulo 2^CNT_DW.
- Stalls: when s_axis_in_tvalid=0, nothing advances. peak_detected_i is ignored unless s_axis_in_tvalid=1.
- FSM states (state_o encoding): SEARCH=0, REFINE=1, TRACK=2.
- SEARCH:
  - On a beat with peak_detected_i=1: latch that beat as the argmax candidate (index, magnitude), go to REFINE, load refine_cnt=SEARCH_LEN-1.
- REFINE:
  - Each beat: if magnitude > best, replace the candidate. Ties keep the earlier index.
  - peak_detected_i is ignored in this state.
  - refine_cnt decrements per beat. On the beat where it reaches 0, the next cycle asserts m_axis_out_tvalid with the candidate.
  - Also set locked_o=1, misses=0, expected=candidate_idx+PERIOD, and go to TRACK.
  - Latency: report one clock after the SEARCH_LEN-th window beat is accepted.
- TRACK:
  - The window covers the beats with index in [expected-TOLERANCE, expected+TOLERANCE], i.e. 2*TOLERANCE+1 beats.
  - Inside the window, only beats with peak_detected_i=1 are candidates; argmax with earliest-wins ties. Flags outside the window are ignored.
  - At the last window beat, with at least one hit:
    - One clock later, report the best candidate on m_axis_out_tvalid.
    - Set expected=best_idx+PERIOD (retiming) and misses=0.
  - At the last window beat, with no hit:
    - No report. misses+1 and expected=expected+PERIOD.
    - If misses reaches MAX_MISSES: locked_o=0, clear the candidate, go to SEARCH. locked_o drops in the same cycle as the state change.
  - A flag on the beat right after the window closes is ignored. Re-acquisition needs a new flag in SEARCH.
- Elaboration check: require PERIOD > SEARCH_LEN+2*TOLERANCE and MAX_MISSES>=1; otherwise $error.
- Outputs are registered. m_axis_out_tdata/tuser hold their last report value between strobes.

Decomposition:
- Package peak_tracker_pkg holds:
  - the state_t enum {SEARCH, REFINE, TRACK}, 2 bits;
  - the STATE_W localparam.
- One natural sub-module, argmax_tracker. It holds the running best index/magnitude with:
  - a clear input;
  - a qualified-sample input;
  - earliest-wins ties.
  - It is shared by REFINE and TRACK.
- The window compare uses a down-counter reloaded at each report or miss. This avoids wide modular comparators.

Test Plan:
- Refine: mags 10, idx100 = 200 with flag, idx102 = 900, idx105 = 900 → one strobe one clock after idx107 accepted, tdata=102, tuser=900, locked_o=1.
- Track: same peak repeated at 102+19200 and 102+38400, flagged → strobes at those indices, misses stay 0, state_o=2.
- Drift: next peak at expected+3 → reported at 19305 and retimed, so the following window is centred at 38505. A peak at expected+5 → ignored, counted as a miss.
- Loss: three consecutive windows with no flag → no strobes, locked_o falls at the end of the third window, state_o=0. A new flag then restarts REFINE.
- Stalls: repeat the refine and track cases with random 50% tvalid → identical indices and magnitudes. No state change on invalid cycles, and a flag with tvalid=0 is ignored.
- Reset: deassert reset_ni mid-REFINE → outputs 0 asynchronously, no strobe. After release, the first beat is index 0 and a peak is re-acquired at the correct index.

Source files
------------

// File: rtl/peak_tracker_pkg.sv
// Shared types for the peak tracker: FSM state encoding as exposed on state_o.
package peak_tracker_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    SEARCH = 2'd0,
    REFINE = 2'd1,
    TRACK  = 2'd2
  } state_t;

endpackage

// File: rtl/peak_tracker_argmax.sv
// Running argmax over qualified samples; later samples replace only on a strictly larger
// magnitude so ties keep the earliest index. upd_* includes the current sample.
module argmax_tracker #(
  parameter int unsigned IN_DW  = 32,
  parameter int unsigned CNT_DW = 32
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              clear_i,
  input  logic              sample_i,
  input  logic [CNT_DW-1:0] idx_i,
  input  logic [IN_DW-1:0]  mag_i,
  output logic              upd_valid_o,
  output logic [CNT_DW-1:0] upd_idx_o,
  output logic [IN_DW-1:0]  upd_mag_o
);

  logic              best_valid_q;
  logic [CNT_DW-1:0] best_idx_q;
  logic [IN_DW-1:0]  best_mag_q;

  always_comb begin
    upd_valid_o = best_valid_q;
    upd_idx_o   = best_idx_q;
    upd_mag_o   = best_mag_q;
    if (sample_i && (!best_valid_q || (mag_i > best_mag_q))) begin
      upd_valid_o = 1'b1;
      upd_idx_o   = idx_i;
      upd_mag_o   = mag_i;
    end
  end

  // Clear wins over the current sample: the caller consumes upd_* in the same cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      best_valid_q <= 1'b0;
      best_idx_q   <= '0;
      best_mag_q   <= '0;
    end else if (clear_i) begin
      best_valid_q <= 1'b0;
      best_idx_q   <= '0;
      best_mag_q   <= '0;
    end else begin
      best_valid_q <= upd_valid_o;
      best_idx_q   <= upd_idx_o;
      best_mag_q   <= upd_mag_o;
    end
  end

endmodule

// File: rtl/peak_tracker.sv
// Refines coarse peak flags to the exact argmax index, then tracks the periodic peak inside a
// tolerance window and drops lock after MAX_MISSES consecutive empty windows.
module peak_tracker
  import peak_tracker_pkg::*;
#(
  parameter int unsigned IN_DW      = 32,
  parameter int unsigned CNT_DW     = 32,
  parameter int unsigned PERIOD     = 19200,
  parameter int unsigned SEARCH_LEN = 8,
  parameter int unsigned TOLERANCE  = 4,
  parameter int unsigned MAX_MISSES = 3
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [IN_DW-1:0]   s_axis_in_tdata,
  input  logic               s_axis_in_tvalid,
  input  logic               peak_detected_i,
  output logic [CNT_DW-1:0]  m_axis_out_tdata,
  output logic [IN_DW-1:0]   m_axis_out_tuser,
  output logic               m_axis_out_tvalid,
  output logic               locked_o,
  output logic [STATE_W-1:0] state_o
);

  if (PERIOD <= SEARCH_LEN + 2 * TOLERANCE || MAX_MISSES < 1) begin : gen_param_check
    $error("peak_tracker: need PERIOD > SEARCH_LEN + 2*TOLERANCE and MAX_MISSES >= 1");
  end

  localparam int unsigned       MissW      = (MAX_MISSES > 1) ? $clog2(MAX_MISSES + 1) : 1;
  localparam logic [CNT_DW-1:0] One        = CNT_DW'(1);
  localparam logic [CNT_DW-1:0] PeriodC    = CNT_DW'(PERIOD);
  localparam logic [CNT_DW-1:0] TolC       = CNT_DW'(TOLERANCE);
  localparam logic [CNT_DW-1:0] WinLast    = CNT_DW'(2 * TOLERANCE);
  localparam logic [CNT_DW-1:0] SearchLast = CNT_DW'(SEARCH_LEN - 1);
  localparam logic [MissW-1:0]  MissLast   = MissW'(MAX_MISSES - 1);

  state_t             state_q, state_d;
  logic [CNT_DW-1:0]  sample_cnt_q, sample_cnt_d;
  // Shared down-counter: beats left in the refine window, or beats left until the last
  // beat of the next tracking window.
  logic [CNT_DW-1:0]  cnt_q, cnt_d;
  logic [CNT_DW-1:0]  expected_q, expected_d;
  logic [MissW-1:0]   misses_q, misses_d;
  logic               locked_q, locked_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_DW-1:0]  out_idx_q, out_idx_d;
  logic [IN_DW-1:0]   out_mag_q, out_mag_d;

  logic               arg_clear, arg_sample, refine_done, win_end;
  logic               upd_valid;
  logic [CNT_DW-1:0]  upd_idx;
  logic [IN_DW-1:0]   upd_mag;

  argmax_tracker #(
    .IN_DW (IN_DW),
    .CNT_DW(CNT_DW)
  ) u_argmax (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .clear_i    (arg_clear),
    .sample_i   (arg_sample),
    .idx_i      (sample_cnt_q),
    .mag_i      (s_axis_in_tdata),
    .upd_valid_o(upd_valid),
    .upd_idx_o  (upd_idx),
    .upd_mag_o  (upd_mag)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    expected_d   = expected_q;
    misses_d     = misses_q;
    locked_d     = locked_q;
    out_valid_d  = 1'b0;
    out_idx_d    = out_idx_q;
    out_mag_d    = out_mag_q;
    arg_clear    = 1'b0;
    arg_sample   = 1'b0;
    refine_done  = 1'b0;
    win_end      = 1'b0;
    sample_cnt_d = s_axis_in_tvalid ? sample_cnt_q + One : sample_cnt_q;

    unique case (state_q)
      SEARCH: begin
        arg_sample = s_axis_in_tvalid & peak_detected_i;
        if (arg_sample) begin
          state_d     = REFINE;
          cnt_d       = SearchLast;
          refine_done = (SEARCH_LEN == 1);
        end
      end
      REFINE: begin
        arg_sample = s_axis_in_tvalid;
        if (s_axis_in_tvalid) begin
          cnt_d       = cnt_q - One;
          refine_done = (cnt_q == One);
        end
      end
      TRACK: begin
        arg_sample = s_axis_in_tvalid & peak_detected_i & (cnt_q <= WinLast);
        if (s_axis_in_tvalid) begin
          if (cnt_q == '0) win_end = 1'b1;
          else             cnt_d   = cnt_q - One;
        end
      end
      default: state_d = SEARCH;
    endcase

    if (refine_done || (win_end && upd_valid)) begin
      out_valid_d = 1'b1;
      out_idx_d   = upd_idx;
      out_mag_d   = upd_mag;
      expected_d  = upd_idx + PeriodC;
      misses_d    = '0;
      locked_d    = 1'b1;
      state_d     = TRACK;
    end else if (win_end) begin
      misses_d   = misses_q + MissW'(1);
      expected_d = expected_q + PeriodC;
      if (misses_q == MissLast) begin
        misses_d = '0;
        locked_d = 1'b0;
        state_d  = SEARCH;
      end
    end

    if (refine_done || win_end) begin
      arg_clear = 1'b1;
      cnt_d     = expected_d + TolC - sample_cnt_q - One;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= SEARCH;
      sample_cnt_q <= '0;
      cnt_q        <= '0;
      expected_q   <= '0;
      misses_q     <= '0;
      locked_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_mag_q    <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      cnt_q        <= cnt_d;
      expected_q   <= expected_d;
      misses_q     <= misses_d;
      locked_q     <= locked_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_mag_q    <= out_mag_d;
    end
  end

  assign m_axis_out_tdata  = out_idx_q;
  assign m_axis_out_tuser  = out_mag_q;
  assign m_axis_out_tvalid = out_valid_q;
  assign locked_o          = locked_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_peak_tracker.sv
// Self-checking bench: scripted and random beats against an index-level reference model.
module tb_peak_tracker;

  localparam int unsigned IN_DW      = 32;
  localparam int unsigned CNT_DW     = 32;
  // Short period so several tracking windows fit in a brief run.
  localparam int unsigned PERIOD     = 64;
  localparam int unsigned SEARCH_LEN = 8;
  localparam int unsigned TOLERANCE  = 4;
  localparam int unsigned MAX_MISSES = 3;

  logic              clk_i = 1'b0;
  logic              reset_ni;
  logic [IN_DW-1:0]  s_axis_in_tdata;
  logic              s_axis_in_tvalid;
  logic              peak_detected_i;
  logic [CNT_DW-1:0] m_axis_out_tdata;
  logic [IN_DW-1:0]  m_axis_out_tuser;
  logic              m_axis_out_tvalid;
  logic              locked_o;
  logic [1:0]        state_o;

  peak_tracker #(
    .IN_DW     (IN_DW),
    .CNT_DW    (CNT_DW),
    .PERIOD    (PERIOD),
    .SEARCH_LEN(SEARCH_LEN),
    .TOLERANCE (TOLERANCE),
    .MAX_MISSES(MAX_MISSES)
  ) dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .s_axis_in_tdata  (s_axis_in_tdata),
    .s_axis_in_tvalid (s_axis_in_tvalid),
    .peak_detected_i  (peak_detected_i),
    .m_axis_out_tdata (m_axis_out_tdata),
    .m_axis_out_tuser (m_axis_out_tuser),
    .m_axis_out_tvalid(m_axis_out_tvalid),
    .locked_o         (locked_o),
    .state_o          (state_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: works on beat indices, the window as [exp-TOL, exp+TOL].
  int          m_mode, m_left, m_miss;
  bit          m_locked, m_cand_v, e_valid;
  logic [31:0] m_idx, m_exp, m_cand_i, m_cand_m, e_tdata, e_tuser;
  logic [31:0] rep_idx[$];
  logic [31:0] rep_mag[$];

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_miss = 0; m_locked = 0; m_cand_v = 0; e_valid = 0;
    m_idx = 0; m_exp = 0; m_cand_i = 0; m_cand_m = 0; e_tdata = 0; e_tuser = 0;
    rep_idx.delete(); rep_mag.delete();
  endtask

  task automatic model_report();
    e_valid  = 1; e_tdata = m_cand_i; e_tuser = m_cand_m;
    m_exp    = m_cand_i + PERIOD; m_miss = 0; m_locked = 1; m_mode = 2; m_cand_v = 0;
  endtask

  task automatic model_beat(input logic [31:0] mag, input bit flag);
    logic [31:0] off;
    e_valid = 0;
    case (m_mode)
      0: if (flag) begin
        m_cand_v = 1; m_cand_i = m_idx; m_cand_m = mag;
        m_mode = 1; m_left = SEARCH_LEN - 1;
        if (m_left == 0) model_report();
      end
      1: begin
        if (mag > m_cand_m) begin m_cand_i = m_idx; m_cand_m = mag; end
        m_left--;
        if (m_left == 0) model_report();
      end
      default: begin
        off = m_idx - (m_exp - TOLERANCE);
        if (flag && off <= 2 * TOLERANCE && (!m_cand_v || mag > m_cand_m)) begin
          m_cand_v = 1; m_cand_i = m_idx; m_cand_m = mag;
        end
        if (m_idx == m_exp + TOLERANCE) begin
          if (m_cand_v) model_report();
          else begin
            m_miss++; m_exp = m_exp + PERIOD;
            if (m_miss == MAX_MISSES) begin
              m_locked = 0; m_mode = 0; m_miss = 0; m_cand_v = 0;
            end
          end
        end
      end
    endcase
    m_idx++;
  endtask

  task automatic drive(input logic valid, input logic [31:0] mag, input logic flag);
    s_axis_in_tvalid = valid; s_axis_in_tdata = mag; peak_detected_i = flag;
    @(posedge clk_i); #1;
    if (valid) model_beat(mag, flag);
    else       e_valid = 0;
    check_eq("tvalid", 32'(m_axis_out_tvalid), 32'(e_valid));
    check_eq("tdata",  m_axis_out_tdata, e_tdata);
    check_eq("tuser",  m_axis_out_tuser, e_tuser);
    check_eq("locked", 32'(locked_o), 32'(m_locked));
    check_eq("state",  32'(state_o), 32'(m_mode));
    if (m_axis_out_tvalid) begin
      rep_idx.push_back(m_axis_out_tdata);
      rep_mag.push_back(m_axis_out_tuser);
    end
  endtask

  function automatic void script(input int idx, output logic [31:0] mag, output bit flag);
    mag = 10; flag = 0;
    case (idx)
      100:                mag = 200;
      102, 105:           mag = 900;
      166, 230, 297, 366: mag = 900;  // 297 is expected+3, 366 lies just past its window
      520:                mag = 300;
      523:                mag = 500;
      default:            ;
    endcase
    if (idx inside {100, 166, 230, 297, 366, 520}) flag = 1;
  endfunction

  task automatic run_script(input int last, input bit stall);
    logic [31:0] mag;
    bit          flag;
    for (int i = 0; i <= last; i++) begin
      script(i, mag, flag);
      if (stall) while ($urandom_range(0, 1) == 1) drive(1'b0, $urandom, 1'($urandom_range(0, 1)));
      drive(1'b1, mag, flag);
    end
  endtask

  task automatic check_reports(input string tag);
    logic [31:0] exp_i[5] = '{102, 166, 230, 297, 523};
    logic [31:0] exp_m[5] = '{900, 900, 900, 900, 500};
    check_eq({tag, "_count"}, 32'(rep_idx.size()), 32'd5);
    for (int k = 0; k < 5 && k < rep_idx.size(); k++) begin
      check_eq({tag, "_idx"}, rep_idx[k], exp_i[k]);
      check_eq({tag, "_mag"}, rep_mag[k], exp_m[k]);
    end
  endtask

  task automatic do_reset();
    reset_ni = 0; s_axis_in_tvalid = 0; s_axis_in_tdata = 0; peak_detected_i = 0;
    repeat (2) @(posedge clk_i);
    #1 reset_ni = 1;
    model_reset();
  endtask

  // Asserts reset between edges and expects outputs to clear without waiting for a clock.
  task automatic async_reset_check();
    #2 reset_ni = 0;
    #1;
    check_eq("rst_tvalid", 32'(m_axis_out_tvalid), 32'd0);
    check_eq("rst_tdata",  m_axis_out_tdata, 32'd0);
    check_eq("rst_tuser",  m_axis_out_tuser, 32'd0);
    check_eq("rst_locked", 32'(locked_o), 32'd0);
    check_eq("rst_state",  32'(state_o), 32'd0);
    s_axis_in_tvalid = 1; s_axis_in_tdata = 999; peak_detected_i = 1;
    repeat (2) begin
      @(posedge clk_i); #1;
      check_eq("rst_hold_state",  32'(state_o), 32'd0);
      check_eq("rst_hold_tvalid", 32'(m_axis_out_tvalid), 32'd0);
    end
    reset_ni = 1;
    model_reset();
  endtask

  initial begin
    do_reset();
    drive(1'b0, 32'd0, 1'b0);

    run_script(600, 1'b0);
    check_reports("valid");
    async_reset_check();

    run_script(600, 1'b1);
    check_reports("stall");

    do_reset();
    run_script(103, 1'b0);
    check_eq("mid_refine_state", 32'(state_o), 32'd1);
    async_reset_check();
    run_script(200, 1'b1);
    check_eq("reacq_count", 32'(rep_idx.size()), 32'd2);
    if (rep_idx.size() > 0) check_eq("reacq_idx", rep_idx[0], 32'd102);

    do_reset();
    for (int c = 0; c < 3000; c++)
      drive(1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 31)),
            1'($urandom_range(0, 15) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
